// File: rtl/ppu_types_pkg.sv
// Shared PPU types: register file view, PPU mode, FIFO pixel and pusher states.
package ppu_types_pkg;

  localparam int unsigned LCD_WIDTH = 160;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAW     = 2'd3
  } ppu_mode_t;

  typedef struct packed {
    logic [7:0] lcdc;
    logic [7:0] scx;
    logic [7:0] bgp;
  } ppu_regs_t;

  typedef struct packed {
    logic [1:0] color;
  } fifo_pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    PUSH    = 2'd2,
    DONE    = 2'd3
  } pusher_state_t;

endpackage

// File: rtl/ppu_util_pkg.sv
// Pure helpers shared by the PPU pixel paths (BGP now, OBP0/OBP1 later).
package ppu_util_pkg;

  // Map a 2-bit color index through an 8-bit DMG palette register.
  function automatic logic [1:0] apply_palette(input logic [7:0] pal, input logic [1:0] color);
    return pal[{color, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ppu_ifs.sv
// Interfaces between the pixel pusher, the background FIFO and the fetchers.
interface FIFO_if;
  logic                       read_en;
  ppu_types_pkg::fifo_pixel_t read_data;
  logic                       empty;

  modport Framebuffer_side (output read_en, input read_data, input empty);
  modport Fetcher_side     (input read_en, output read_data, output empty);
endinterface

interface RenderingControl_if;
  logic       stall;
  logic [7:0] pixel_x;

  modport Framebuffer_side (input stall, output pixel_x);
  modport Fetcher_side     (output stall, input pixel_x);
endinterface

// File: rtl/ppu_pixel_pusher.sv
// Pops background pixels during DRAW, drops SCX[2:0] of them for fine scroll,
// maps the rest through BGP and presents them to the LCD with their X.
module ppu_pixel_pusher #(
  parameter int unsigned LCD_WIDTH = ppu_types_pkg::LCD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  ppu_types_pkg::ppu_regs_t regs,
  input  ppu_types_pkg::ppu_mode_t mode,
  FIFO_if.Framebuffer_side         fifo,
  RenderingControl_if.Framebuffer_side rc,
  output logic                     lcd_valid,
  output logic [1:0]               lcd_shade,
  output logic [7:0]               lcd_x,
  output logic                     line_done
);
  import ppu_types_pkg::*;
  import ppu_util_pkg::*;

  localparam logic [7:0] LAST_X = 8'(LCD_WIDTH - 1);

  pusher_state_t state_q, state_d;
  logic [2:0]    discard_cnt_q, discard_cnt_d;
  logic [7:0]    pixel_x_q, pixel_x_d;
  logic          lcd_valid_q, lcd_valid_d;
  logic [1:0]    lcd_shade_q, lcd_shade_d;
  logic [7:0]    lcd_x_q, lcd_x_d;
  logic          line_done_q, line_done_d;

  logic in_draw;
  logic pop;
  logic unused_regs;

  assign unused_regs = ^{regs.lcdc[7:1], regs.scx[7:3]};

  // Combinational pop qualifier; also the FIFO read strobe.
  always_comb begin
    in_draw = (mode == DRAW);
    pop     = ((state_q == DISCARD) || (state_q == PUSH)) && in_draw &&
              !fifo.empty && !rc.stall;
  end

  assign fifo.read_en = pop;
  assign rc.pixel_x   = pixel_x_q;
  assign lcd_valid    = lcd_valid_q;
  assign lcd_shade    = lcd_shade_q;
  assign lcd_x        = lcd_x_q;
  assign line_done    = line_done_q;

  // Next-state and registered-output logic; abort has priority over holds.
  always_comb begin
    state_d       = state_q;
    discard_cnt_d = discard_cnt_q;
    pixel_x_d     = pixel_x_q;
    lcd_valid_d   = 1'b0;
    lcd_shade_d   = lcd_shade_q;
    lcd_x_d       = lcd_x_q;
    line_done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_draw) begin
          discard_cnt_d = regs.scx[2:0];
          pixel_x_d     = '0;
          state_d       = (regs.scx[2:0] != 3'd0) ? DISCARD : PUSH;
        end
      end
      DISCARD: begin
        if (!in_draw) begin
          state_d   = IDLE;
          pixel_x_d = '0;
        end else if (pop) begin
          discard_cnt_d = discard_cnt_q - 3'd1;
          if (discard_cnt_q == 3'd1) state_d = PUSH;
        end
      end
      PUSH: begin
        if (!in_draw) begin
          state_d   = IDLE;
          pixel_x_d = '0;
        end else if (pop) begin
          lcd_valid_d = 1'b1;
          lcd_shade_d = regs.lcdc[0] ? apply_palette(regs.bgp, fifo.read_data.color) : 2'd0;
          lcd_x_d     = pixel_x_q;
          if (pixel_x_q == LAST_X) begin
            state_d     = DONE;
            line_done_d = 1'b1;
          end else begin
            pixel_x_d = pixel_x_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (!in_draw) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      discard_cnt_q <= '0;
      pixel_x_q     <= '0;
      lcd_valid_q   <= 1'b0;
      lcd_shade_q   <= '0;
      lcd_x_q       <= '0;
      line_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      discard_cnt_q <= discard_cnt_d;
      pixel_x_q     <= pixel_x_d;
      lcd_valid_q   <= lcd_valid_d;
      lcd_shade_q   <= lcd_shade_d;
      lcd_x_q       <= lcd_x_d;
      line_done_q   <= line_done_d;
    end
  end

endmodule

// File: tb/tb_ppu_pixel_pusher.sv
// Self-checking bench for ppu_pixel_pusher: line-level reference model plus
// directed line scenarios and randomized lines with holds, aborts and resets.
module tb_ppu_pixel_pusher;
  import ppu_types_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  ppu_regs_t  regs;
  ppu_mode_t  mode;
  logic       lcd_valid;
  logic [1:0] lcd_shade;
  logic [7:0] lcd_x;
  logic       line_done;

  FIFO_if             fifo ();
  RenderingControl_if rc ();

  logic        f_empty = 1'b0;
  logic        f_stall = 1'b0;
  logic [1:0]  colors [512];
  int unsigned ptr = 0;

  assign fifo.empty           = f_empty;
  assign rc.stall             = f_stall;
  assign fifo.read_data.color = colors[ptr % 512];

  ppu_pixel_pusher #(.LCD_WIDTH(160)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .regs      (regs),
    .mode      (mode),
    .fifo      (fifo),
    .rc        (rc),
    .lcd_valid (lcd_valid),
    .lcd_shade (lcd_shade),
    .lcd_x     (lcd_x),
    .line_done (line_done)
  );

  always #5 clk = ~clk;

  // FIFO source: advance to the next stored pixel on every pop.
  always @(posedge clk) if (fifo.read_en === 1'b1) ptr <= ptr + 1;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned n_pops   = 0;
  int unsigned n_valid  = 0;
  int unsigned n_done   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned ref_shade(input int unsigned bgp, input int unsigned c, input bit en);
    return en ? ((bgp >> (2 * c)) % 4) : 0;
  endfunction

  // Line-level model: a line is (scx + 160) pops; pop k < scx is dropped,
  // otherwise it becomes pixel k - scx.
  bit          m_active = 1'b0;
  int unsigned m_scx = 0, m_pops = 0, m_px = 0;
  bit          e_valid = 1'b0, e_done = 1'b0;
  int unsigned e_x = 0, e_shade = 0;

  always @(negedge clk) begin
    bit          exp_pop;
    int unsigned xx;
    if (!rst_n) begin
      chk("rst_lcd_valid", lcd_valid, 0);
      chk("rst_lcd_shade", lcd_shade, 0);
      chk("rst_lcd_x", lcd_x, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_pixel_x", rc.pixel_x, 0);
      chk("rst_read_en", fifo.read_en, 0);
      m_active = 1'b0; m_pops = 0; m_px = 0; e_valid = 1'b0; e_done = 1'b0;
    end else begin
      chk("lcd_valid", lcd_valid, e_valid);
      chk("line_done", line_done, e_done);
      chk("pixel_x", rc.pixel_x, m_px);
      if (e_valid) begin
        chk("lcd_shade", lcd_shade, e_shade);
        chk("lcd_x", lcd_x, e_x);
      end
      exp_pop = m_active && (m_pops < m_scx + 160) && (mode == DRAW) && !f_empty && !f_stall;
      chk("read_en", fifo.read_en, exp_pop);
      n_pops  += (fifo.read_en === 1'b1) ? 1 : 0;
      n_valid += (lcd_valid === 1'b1) ? 1 : 0;
      n_done  += (line_done === 1'b1) ? 1 : 0;

      e_valid = 1'b0;
      e_done  = 1'b0;
      if (!m_active) begin
        if (mode == DRAW) begin
          m_active = 1'b1; m_pops = 0; m_scx = regs.scx % 8; m_px = 0;
        end
      end else if (mode != DRAW) begin
        if (m_pops < m_scx + 160) m_px = 0;
        m_active = 1'b0;
      end else if (exp_pop) begin
        if (m_pops >= m_scx) begin
          xx      = m_pops - m_scx;
          e_valid = 1'b1;
          e_x     = xx;
          e_shade = ref_shade(regs.bgp, fifo.read_data.color, regs.lcdc[0]);
          e_done  = (xx == 159);
          m_px    = (xx == 159) ? 159 : xx + 1;
        end
        m_pops++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < 512; i++) colors[i] = rnd ? 2'($urandom) : 2'(i % 4);
  endtask

  // Run one line. Holds are random (hold_pct) or the scripted stall/empty
  // pattern (t3); the line may end by abort, by reset, or by line_done.
  task automatic run_line(input int hold_pct, input bit t3, input int abort_x,
                          input int abort_cyc, input int reset_x, input bit jitter,
                          input int exp_pops, input int exp_valid);
    int unsigned p0, v0, d0, hc;
    bit          ended, done_seen;
    p0 = n_pops; v0 = n_valid; d0 = n_done; hc = 0; ended = 0; done_seen = 0;
    mode = DRAW;
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      if (t3) begin
        f_stall = (rc.pixel_x == 8'd8) && (hc < 6);
        if (f_stall) hc++;
        f_empty = cyc[0];
      end else begin
        f_stall = ($urandom_range(99) < hold_pct);
        f_empty = ($urandom_range(99) < hold_pct);
      end
      if (jitter && cyc > 0) regs.scx = 8'($urandom);
      if ((abort_x >= 0 && int'(rc.pixel_x) == abort_x) || cyc == abort_cyc) begin
        mode = HBLANK;
        step;
        chk("abort_pixel_x", rc.pixel_x, 0);
        chk("abort_no_line_done", line_done, 0);
        chk("abort_no_valid", lcd_valid, 0);
        ended = 1;
      end else if (reset_x >= 0 && int'(rc.pixel_x) == reset_x) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", lcd_valid, 0);
        chk("async_rst_x", lcd_x, 0);
        chk("async_rst_pixel_x", rc.pixel_x, 0);
        chk("async_rst_read_en", fifo.read_en, 0);
        step;
        step;
        rst_n = 1'b1;
        ended = 1;
      end else begin
        step;
        if (line_done === 1'b1) begin
          chk("done_read_en", fifo.read_en, 0);
          ended = 1;
          done_seen = 1;
        end
      end
    end
    chk("line_end_in_budget", ended, 1);
    mode = HBLANK;
    f_stall = 1'b0;
    f_empty = 1'b0;
    repeat (3) step;
    if (done_seen) begin
      if (exp_pops >= 0) chk("line_pops", n_pops - p0, exp_pops);
      if (exp_valid >= 0) chk("line_pixels", n_valid - v0, exp_valid);
      chk("line_done_count", n_done - d0, 1);
    end
  endtask

  initial begin
    int unsigned s;
    regs = '0;
    mode = HBLANK;
    fill(1'b0);

    chk("pal_E4_c2", ref_shade(8'hE4, 2, 1'b1), 2);
    chk("pal_1B_c0", ref_shade(8'h1B, 0, 1'b1), 3);
    chk("pal_1B_c3", ref_shade(8'h1B, 3, 1'b1), 0);
    chk("pal_off", ref_shade(8'hFF, 3, 1'b0), 0);

    repeat (3) step;
    rst_n = 1'b1;
    step;

    // SCX 0, no holds, identity palette.
    regs.scx = 8'd0; regs.bgp = 8'hE4; regs.lcdc = 8'h01;
    run_line(0, 1'b0, -1, -1, -1, 1'b0, 160, 160);

    // Fine scroll of 5.
    regs.scx = 8'd5;
    run_line(0, 1'b0, -1, -1, -1, 1'b0, 165, 160);

    // Stall at X=8 with empty toggling.
    regs.scx = 8'd0;
    run_line(0, 1'b1, -1, -1, -1, 1'b0, 160, 160);

    // Inverted palette, then BG disabled.
    regs.bgp = 8'h1B;
    run_line(0, 1'b0, -1, -1, -1, 1'b0, 160, 160);
    regs.lcdc = 8'h00;
    run_line(10, 1'b0, -1, -1, -1, 1'b0, 160, 160);

    // Abort at X=50, then a fresh line with SCX 2.
    regs.lcdc = 8'h01; regs.bgp = 8'hE4;
    run_line(0, 1'b0, 50, -1, -1, 1'b0, -1, -1);
    regs.scx = 8'd2;
    run_line(0, 1'b0, -1, -1, -1, 1'b0, 162, 160);

    // Reset at X=100, then a fresh line.
    regs.scx = 8'd3;
    run_line(0, 1'b0, -1, -1, 100, 1'b0, -1, -1);
    run_line(0, 1'b0, -1, -1, -1, 1'b0, 163, 160);

    // Randomized lines.
    fill(1'b1);
    for (int n = 0; n < 12; n++) begin
      regs.scx  = 8'($urandom);
      regs.bgp  = 8'($urandom);
      regs.lcdc = 8'($urandom);
      s = regs.scx % 8;
      if (n % 4 == 3)
        run_line(25, 1'b0, -1, $urandom_range(1, 40), -1, 1'b1, -1, -1);
      else
        run_line(25, 1'b0, -1, -1, -1, 1'b1, int'(160 + s), 160);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_pixel_pusher.md
# ppu_pixel_pusher

Downstream consumer of the background pixel FIFO in the PPU draw path. During mode 3 (DRAW) it pops one pixel per cycle from the FIFO and discards the first SCX[2:0] pixels of the line for fine scroll. Surviving pixels are mapped through BGP and emitted to the LCD as 2-bit shades with an X coordinate. It owns `pixel_x`, which the fetchers read through the rendering-control interface, and it honours `stall` from the object fetcher.

## Interface
Parameters:
- `LCD_WIDTH`, 160: visible pixels per line.

Ports:
- `clk`  in  1  PPU dot clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `regs`  in  ppu_regs_t  uses `scx`, `bgp`, and `lcdc[0]` (BG enable).
- `mode`  in  ppu_mode_t  current PPU mode; only DRAW is acted on.
- `fifo`  modport  FIFO_if.Framebuffer_side  drives `read_en`; samples `read_data` and `empty`.
- `rc`  modport  RenderingControl_if.Framebuffer_side  samples `stall`; drives `pixel_x`.
- `lcd_valid`  out  1  a shade is presented this cycle.
- `lcd_shade`  out  2  DMG shade (0 = white … 3 = black).
- `lcd_x`  out  8  X coordinate of `lcd_shade`, 0..159.
- `line_done`  out  1  one-cycle pulse after pixel 159 is emitted.

## Operation
- FIFO is show-ahead: `read_data` is valid whenever `empty` = 0, and a pop happens on any cycle with `read_en` = 1.
- `pop` = `read_en` = (state ∈ {DISCARD, PUSH}) ∧ `mode` == DRAW ∧ ¬`empty` ∧ ¬`stall`. This is combinational, with no registers in the path.
- State machine:
  - IDLE: wait for `mode` == DRAW. On entry latch `discard_cnt` ← `scx[2:0]` and `pixel_x` ← 0. Go to DISCARD if `discard_cnt` ≠ 0, else PUSH.
  - DISCARD: each pop decrements `discard_cnt`, and the popped pixel is dropped. No `lcd_valid`. `pixel_x` is held at 0. When the pop takes the count 1 → 0, go to PUSH.
  - PUSH: each pop emits a pixel and increments `pixel_x`. The pop at `pixel_x` == LCD_WIDTH-1 goes to DONE.
  - DONE: no pops. Return to IDLE when `mode` ≠ DRAW.
- Abort: `mode` leaving DRAW while in DISCARD or PUSH:
  - Go to IDLE next cycle and clear `pixel_x`.
  - No `line_done`. A pop in flight on that cycle is suppressed.
- Shade mapping, for c = `read_data.color`:
  - `lcd_shade` = `bgp[2c+1:2c]` when `lcdc[0]` = 1.
  - `lcd_shade` = 0 when `lcdc[0]` = 0; the pixel is still popped and counted.
- `pixel_x` is 8 bits and never exceeds 159 (no wrap). `scx` is sampled only on IDLE→DRAW entry; changes mid-line are ignored.
- `stall` and `empty` are equivalent holds: state, `pixel_x` and `discard_cnt` are frozen. Simultaneous `stall` and `empty` is the same hold.

## Timing
- All outputs registered. Reset values: `lcd_valid` 0, `lcd_shade` 0, `lcd_x` 0, `line_done` 0, `pixel_x` 0, state IDLE, `discard_cnt` 0.
- `read_en` is combinational and 0 during reset.
- Pop at cycle N:
  - `lcd_valid`, `lcd_shade` and `lcd_x` (= `pixel_x` before increment) are presented at N+1.
  - `rc.pixel_x` shows the incremented value at N+1.
- `line_done` pulses at N+1 for the pop of X = 159, coincident with that pixel's `lcd_valid`.
- Throughput is 1 pixel/cycle. With no holds, a line is 160 + SCX[2:0] pops, and the first pop happens on the first cycle in DISCARD or PUSH.
- Reset mid-line returns to IDLE immediately (asynchronous); the next DRAW starts a fresh line.

## Structure
- `ppu_types_pkg` holds:
  - `pusher_state_t` (IDLE, DISCARD, PUSH, DONE).
  - `LCD_WIDTH` (shared with the framebuffer).
- `ppu_util_pkg` holds `apply_palette(bgp, color)`, a pure function later reused for OBP0/OBP1.
- Single module, no sub-modules. Estimated 150–250 lines.

## Test plan
- SCX = 0, FIFO never empty, BGP = 0xE4, colors cycling 0..3 → 160 consecutive `lcd_valid` with `lcd_shade` = color and `lcd_x` 0..159, `line_done` on the last, then `read_en` = 0.
- SCX = 5 → first 5 pops produce no `lcd_valid` with `pixel_x` = 0, 6th popped pixel appears at `lcd_x` = 0, 165 pops total.
- `stall` = 1 for 6 cycles when `pixel_x` = 8, plus `empty` toggling every other cycle → `read_en` = 0 while held, `pixel_x` frozen at 8, no skipped or duplicated X values, 160 pixels total.
- BGP = 0x1B → colors 0..3 give shades 3,2,1,0; then `lcdc[0]` = 0 → all shades 0 while `pixel_x` still advances.
- Mode → HBLANK at `pixel_x` = 50 → IDLE next cycle, `pixel_x` = 0, no `line_done`; next DRAW with SCX = 2 discards 2 again.
- `rst_n` low mid-PUSH at X = 100 → all outputs 0 asynchronously, `read_en` = 0, state IDLE after release.
